mc_control_fsm: RTL and testbench
=================================

# mc_control_fsm

Multi-cycle control unit for the simple MIPS processor. It sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives the IF stage's `PC_en` and branch-select inputs, and it issues the register-file, ALU and data-memory controls. It decodes the latched opcode/funct and handles a ready/ack data-memory handshake with timeout, and it flags illegal instructions.

## Interface
- `MEM_TIMEOUT`, default 15: maximum number of cycles spent in MEM waiting for `mem_ack` (1..255).
- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous reset, active-low (0 = reset).
- `opcode` input 6: instr[31:26] from the IF stage.
- `funct` input 6: instr[5:0] from the IF stage.
- `alu_zero` input 1: ALU zero flag.
- `mem_ack` input 1: data-memory completion.
- `PC_en` output 1: PC load enable (IF stage).
- `PC_sel` output 1: IF mux select, 1 = PC+4+immed, 0 = PC+4.
- `RF_we` output 1: register-file write enable.
- `RF_wr_sel` output 1: write data source, 0 = ALU, 1 = memory.
- `RF_dst_sel` output 1: destination register, 0 = rt, 1 = rd.
- `ALU_src_sel` output 1: ALU B operand, 0 = register, 1 = immediate.
- `ALU_func` output 4: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 slt.
- `imm_sext` output 1: 1 = sign-extend, 0 = zero-extend.
- `MEM_req` output 1: memory request.
- `MEM_we` output 1: memory write.
- `illegal` output 1: one-cycle pulse on an undecodable instruction or a memory timeout.

## Operation
- **Outputs:** every output is a function of registered state only (state, latched opcode/funct, latched zero). No input drives an output combinationally.
- **Instruction classes:**
  - R-type (opcode 000000): funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - addi (001000): add, sign-extend.
  - ori (001101): or, zero-extend.
  - lw (100011) and sw (101011): add, sign-extend.
  - beq (000100) and bne (000101): sub, sign-extend.
  - Anything else, including an unlisted R funct, is illegal.
- **FETCH:** all controls 0. Go to DECODE.
- **DECODE:** latch `opcode`/`funct`.
  - Legal: go to EXEC.
  - Illegal: go to ILLEGAL.
- **EXEC:** drive `ALU_func`, `ALU_src_sel` (1 for I/mem), `imm_sext`.
  - Branch: latch `alu_zero`, then go to BRANCH.
  - lw/sw: clear the timeout counter, then go to MEM.
  - Other instructions: go to WB.
- **MEM:** `MEM_req` = 1; `MEM_we` = 1 for sw only. ALU controls are held from EXEC.
  - `mem_ack` sampled 1: go to WB.
  - Counter reaches `MEM_TIMEOUT` cycles without ack: set the timeout flag, go to WB.
- **WB:** `PC_en` = 1 and `PC_sel` = 0.
  - `RF_we` = 1 for R/addi/ori/lw when there is no timeout.
  - `RF_wr_sel` = 1 for lw.
  - `RF_dst_sel` = 1 for R-type.
  - `illegal` = timeout flag.
  - Next state: FETCH.
- **BRANCH:** `PC_en` = 1.
  - `PC_sel` = latched zero for beq, ~latched zero for bne.
  - Next state: FETCH.
- **ILLEGAL:** `PC_en` = 1, `PC_sel` = 0, `illegal` = 1. Next state: FETCH. The instruction is skipped with no RF or memory side effects.
- **Timeout counter:** ceil(log2(MEM_TIMEOUT+1)) bits. Increments each MEM cycle and saturates. It is never observed outside MEM.
- **Reset (`reset` low):** state is FETCH immediately, asynchronously, in any state including mid-MEM. All outputs are 0, the latches and timeout flag are cleared, and `MEM_req` drops within the same cycle.

## Timing
- **Instruction latency in cycles, FETCH through PC update:**
  - R/addi/ori: 4.
  - beq/bne: 4.
  - illegal: 3.
  - lw/sw: 5 + w, where w = number of MEM cycles before ack (0-wait ack gives exactly 1 MEM cycle).
  - Timeout: 4 + MEM_TIMEOUT.
- **`PC_en`:** high for exactly one cycle per instruction, in the final state. The PC updates on the following rising edge, and that next state is always FETCH.
- **Instruction stability:** the IF stage presents the instruction on the falling edge inside FETCH. `opcode`/`funct` must be stable from that edge through the DECODE rising edge.
- **Handshake:**
  - `MEM_req` stays high until the edge that samples `mem_ack` = 1 (or the timeout), then falls in WB.
  - `mem_ack` is ignored outside MEM.
  - Ack arriving on the same edge as the timeout: the ack wins, with no timeout.

## Test plan
- **Reset:** hold `reset` = 0 for 3 cycles, then release → state FETCH, all outputs 0, first `PC_en` pulse on cycle 4 for an R-type add.
- **R-type add then slt** (opcode 000000, funct 100000 then 101010) → `ALU_func` 0000 then 0100; `RF_we` = `RF_dst_sel` = `PC_en` = 1 in cycles 4 and 8 only.
- **beq:**
  - `alu_zero` = 1 → `PC_sel` = 1 with `PC_en` in cycle 4.
  - bne with `alu_zero` = 1 → `PC_sel` = 0.
- **lw with `mem_ack` delayed 3 cycles** → `MEM_req` high for 4 cycles, `MEM_we` = 0, WB asserts `RF_we` = `RF_wr_sel` = 1, total 8 cycles.
- **sw with `mem_ack` never asserted, `MEM_TIMEOUT` = 15** → `MEM_we` = 1 for 15 cycles, then a WB with `illegal` = 1, `RF_we` = 0, `PC_en` = 1.
- **Opcode 111111:** → `illegal` pulse and `PC_en` in cycle 3, no `RF_we`/`MEM_req`.
- **Reset mid-MEM:** assert `reset` = 0 mid-MEM → `MEM_req` falls immediately and the next instruction restarts at FETCH.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit for the simple MIPS core. Steps each instruction through
// FETCH/DECODE/EXEC and then MEM/WB, BRANCH or ILLEGAL. All outputs come from registered
// state so the datapath sees glitch-free controls for the whole cycle.
module mc_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ack,
  output logic       PC_en,
  output logic       PC_sel,
  output logic       RF_we,
  output logic       RF_wr_sel,
  output logic       RF_dst_sel,
  output logic       ALU_src_sel,
  output logic [3:0] ALU_func,
  output logic       imm_sext,
  output logic       MEM_req,
  output logic       MEM_we,
  output logic       illegal
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(MEM_TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpBne  = 6'b000101;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnSlt = 6'b101010;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;
  localparam logic [3:0] AluSlt = 4'b0100;

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StBranch,
    StIllegal
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      op_q, op_d;
  logic [5:0]      fn_q, fn_d;
  logic            zero_q, zero_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tmo_q, tmo_d;

  logic       is_r, is_addi, is_ori, is_lw, is_sw, is_beq, is_bne;
  logic [3:0] alu_dec;

  // Legality check on the live instruction, used only for the DECODE transition.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OpR: begin
        case (fn)
          FnAdd, FnSub, FnAnd, FnOr, FnSlt: ok = 1'b1;
          default:                           ok = 1'b0;
        endcase
      end
      OpAddi, OpOri, OpLw, OpSw, OpBeq, OpBne: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // State and instruction latches; reset returns to FETCH at once, even mid-MEM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
      op_q    <= '0;
      fn_q    <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fn_q    <= fn_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Instruction class and ALU operation from the latched opcode/funct.
  always_comb begin
    is_r    = 1'b0;
    is_addi = 1'b0;
    is_ori  = 1'b0;
    is_lw   = 1'b0;
    is_sw   = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    alu_dec = AluAdd;
    case (op_q)
      OpR: begin
        is_r = 1'b1;
        case (fn_q)
          FnSub:   alu_dec = AluSub;
          FnAnd:   alu_dec = AluAnd;
          FnOr:    alu_dec = AluOr;
          FnSlt:   alu_dec = AluSlt;
          default: alu_dec = AluAdd;
        endcase
      end
      OpAddi: is_addi = 1'b1;
      OpOri: begin
        is_ori  = 1'b1;
        alu_dec = AluOr;
      end
      OpLw:   is_lw = 1'b1;
      OpSw:   is_sw = 1'b1;
      OpBeq: begin
        is_beq  = 1'b1;
        alu_dec = AluSub;
      end
      OpBne: begin
        is_bne  = 1'b1;
        alu_dec = AluSub;
      end
      default: ;
    endcase
  end

  // Next-state logic, including the MEM wait counter and timeout flag.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fn_d    = fn_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        op_d    = opcode;
        fn_d    = funct;
        state_d = is_legal(opcode, funct) ? StExec : StIllegal;
      end
      StExec: begin
        tmo_d = 1'b0;
        if (is_beq || is_bne) begin
          zero_d  = alu_zero;
          state_d = StBranch;
        end else if (is_lw || is_sw) begin
          cnt_d   = '0;
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end
        // An ack on the final allowed cycle takes priority over the timeout.
        if (mem_ack) begin
          state_d = StWb;
        end else if (cnt_q == CntLast) begin
          tmo_d   = 1'b1;
          state_d = StWb;
        end
      end
      StWb, StBranch, StIllegal: state_d = StFetch;
      default: state_d = StFetch;
    endcase
  end

  // Moore outputs decoded from state and latched instruction fields.
  always_comb begin
    PC_en       = 1'b0;
    PC_sel      = 1'b0;
    RF_we       = 1'b0;
    RF_wr_sel   = 1'b0;
    RF_dst_sel  = 1'b0;
    ALU_src_sel = 1'b0;
    ALU_func    = 4'b0000;
    imm_sext    = 1'b0;
    MEM_req     = 1'b0;
    MEM_we      = 1'b0;
    illegal     = 1'b0;
    // ALU controls persist into WB so the unregistered ALU result stays valid for write-back.
    if (state_q == StExec || state_q == StMem || state_q == StWb) begin
      ALU_func    = alu_dec;
      ALU_src_sel = is_addi | is_ori | is_lw | is_sw;
      imm_sext    = is_addi | is_lw | is_sw | is_beq | is_bne;
    end
    case (state_q)
      StMem: begin
        MEM_req = 1'b1;
        MEM_we  = is_sw;
      end
      StWb: begin
        PC_en      = 1'b1;
        RF_we      = (is_r | is_addi | is_ori | is_lw) & ~tmo_q;
        RF_wr_sel  = is_lw;
        RF_dst_sel = is_r;
        illegal    = tmo_q;
      end
      StBranch: begin
        PC_en  = 1'b1;
        PC_sel = is_beq ? zero_q : ~zero_q;
      end
      StIllegal: begin
        PC_en   = 1'b1;
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: directed vector table, reset corner cases and random
// instructions, all checked cycle by cycle against an instruction-level trace model.
module tb_mc_control_fsm;

  localparam int unsigned T = 15;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic       mem_ack;
  logic       PC_en, PC_sel, RF_we, RF_wr_sel, RF_dst_sel, ALU_src_sel;
  logic [3:0] ALU_func;
  logic       imm_sext, MEM_req, MEM_we, illegal;

  mc_control_fsm #(.MEM_TIMEOUT(T)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .alu_zero   (alu_zero),
    .mem_ack    (mem_ack),
    .PC_en      (PC_en),
    .PC_sel     (PC_sel),
    .RF_we      (RF_we),
    .RF_wr_sel  (RF_wr_sel),
    .RF_dst_sel (RF_dst_sel),
    .ALU_src_sel(ALU_src_sel),
    .ALU_func   (ALU_func),
    .imm_sext   (imm_sext),
    .MEM_req    (MEM_req),
    .MEM_we     (MEM_we),
    .illegal    (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Output vector: PC_en PC_sel RF_we RF_wr_sel RF_dst_sel | ALU_src ALU_func imm_sext | req we ill
  logic [13:0] act;
  assign act = {PC_en, PC_sel, RF_we, RF_wr_sel, RF_dst_sel, ALU_src_sel, ALU_func, imm_sext,
                MEM_req, MEM_we, illegal};
  localparam logic [13:0] WbMask = 14'b11_1110_0000_0111;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Instruction-level reference: what the instruction is, and what each cycle should show.
  typedef struct packed {
    logic       legal;
    logic       is_r;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_bne;
    logic       wr_rf;
    logic       src;
    logic       sext;
    logic [3:0] alu;
  } cls_t;

  function automatic cls_t classify(input logic [5:0] op, input logic [5:0] fn);
    cls_t k;
    k = '0;
    case (op)
      6'h00: begin
        k.is_r = 1; k.wr_rf = 1; k.legal = 1;
        case (fn)
          6'h20: k.alu = 4'd0;
          6'h22: k.alu = 4'd1;
          6'h24: k.alu = 4'd2;
          6'h25: k.alu = 4'd3;
          6'h2a: k.alu = 4'd4;
          default: k.legal = 0;
        endcase
      end
      6'h08: begin k.legal = 1; k.wr_rf = 1; k.src = 1; k.sext = 1; k.alu = 4'd0; end
      6'h0d: begin k.legal = 1; k.wr_rf = 1; k.src = 1; k.sext = 0; k.alu = 4'd3; end
      6'h23: begin k.legal = 1; k.is_lw = 1; k.wr_rf = 1; k.src = 1; k.sext = 1; end
      6'h2b: begin k.legal = 1; k.is_sw = 1; k.src = 1; k.sext = 1; end
      6'h04: begin k.legal = 1; k.is_beq = 1; k.sext = 1; k.alu = 4'd1; end
      6'h05: begin k.legal = 1; k.is_bne = 1; k.sext = 1; k.alu = 4'd1; end
      default: ;
    endcase
    return k;
  endfunction

  // Cycles from FETCH to the PC_en cycle; w = MEM cycles before the ack.
  function automatic int model_len(input cls_t k, input int w);
    if (!k.legal) return 3;
    if (k.is_lw || k.is_sw) return (w >= int'(T)) ? 4 + int'(T) : 5 + w;
    return 4;
  endfunction

  function automatic logic [13:0] model_out(input cls_t k, input logic z, input int w,
                                            input int c);
    int          len;
    logic [13:0] e;
    logic        tmo;
    len = model_len(k, w);
    e   = '0;
    tmo = (k.is_lw || k.is_sw) && (w >= int'(T));
    if (!k.legal) begin
      if (c == 3) begin e[13] = 1'b1; e[0] = 1'b1; end
    end else if (c == len) begin
      e[13] = 1'b1;
      if (k.is_beq || k.is_bne) begin
        e[12] = k.is_beq ? z : ~z;
      end else begin
        e[11] = k.wr_rf & ~tmo;
        e[10] = k.is_lw;
        e[9]  = k.is_r;
        e[0]  = tmo;
      end
    end else if (c >= 3) begin
      e[8:3] = {k.src, k.alu, k.sext};
      if (c >= 4) begin
        e[2] = 1'b1;
        e[1] = k.is_sw;
      end
    end
    return e;
  endfunction

  int         obs_len, obs_req, obs_we;
  logic [3:0] obs_alu;
  logic       obs_pcsel, obs_rfwe, obs_ill;

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Runs one instruction starting at a negedge in FETCH; ends at the negedge of the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int w);
    cls_t        k;
    int          len;
    bit          done;
    bit          is_mem;
    logic [13:0] e, m;
    k      = classify(op, fn);
    len    = model_len(k, w);
    is_mem = k.legal && (k.is_lw || k.is_sw);
    done   = 0;
    obs_len = 0; obs_req = 0; obs_we = 0; obs_alu = '0;
    obs_pcsel = 0; obs_rfwe = 0; obs_ill = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c <= len) begin
        e = model_out(k, z, w, c);
        m = (k.legal && !(k.is_beq || k.is_bne) && c == len) ? WbMask : 14'h3fff;
        check($sformatf("cyc%0d op=%02h fn=%02h w=%0d", c, op, fn, w), 32'(act & m),
              32'(e & m));
      end
      if (c == 3) obs_alu = ALU_func;
      obs_req += int'(MEM_req);
      obs_we  += int'(MEM_we);
      if (PC_en) begin
        obs_len = c; obs_pcsel = PC_sel; obs_rfwe = RF_we; obs_ill = illegal;
        done = 1;
      end
      if (c <= 2) begin
        opcode = op;
        funct  = fn;
      end else begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end
      alu_zero = (c == 3) ? z : 1'($urandom);
      if (is_mem && c >= 4 && c < len) mem_ack = (c - 3 == w + 1);
      else                             mem_ack = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (done) break;
    end
    check($sformatf("latency op=%02h fn=%02h w=%0d", op, fn, w), 32'(obs_len), 32'(len));
    if (obs_len != len) do_reset();
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         w;
    int         len;
    logic [3:0] alu;
    logic       pcsel;
    logic       rfwe;
    logic       ill;
    int         req;
    int         we;
    string      name;
  } vec_t;

  vec_t       tbl[19];
  logic [5:0] rfn[5];

  initial begin
    logic [5:0] op, fn;
    int         w;
    tbl[0]  = '{6'h00, 6'h20, 1'b0, 0,   4,  4'd0, 1'b0, 1'b1, 1'b0, 0,  0,  "add"};
    tbl[1]  = '{6'h00, 6'h2a, 1'b0, 0,   4,  4'd4, 1'b0, 1'b1, 1'b0, 0,  0,  "slt"};
    tbl[2]  = '{6'h00, 6'h22, 1'b0, 0,   4,  4'd1, 1'b0, 1'b1, 1'b0, 0,  0,  "sub"};
    tbl[3]  = '{6'h00, 6'h24, 1'b0, 0,   4,  4'd2, 1'b0, 1'b1, 1'b0, 0,  0,  "and"};
    tbl[4]  = '{6'h00, 6'h25, 1'b0, 0,   4,  4'd3, 1'b0, 1'b1, 1'b0, 0,  0,  "or"};
    tbl[5]  = '{6'h08, 6'h3f, 1'b0, 0,   4,  4'd0, 1'b0, 1'b1, 1'b0, 0,  0,  "addi"};
    tbl[6]  = '{6'h0d, 6'h00, 1'b0, 0,   4,  4'd3, 1'b0, 1'b1, 1'b0, 0,  0,  "ori"};
    tbl[7]  = '{6'h04, 6'h00, 1'b1, 0,   4,  4'd1, 1'b1, 1'b0, 1'b0, 0,  0,  "beq_z1"};
    tbl[8]  = '{6'h04, 6'h00, 1'b0, 0,   4,  4'd1, 1'b0, 1'b0, 1'b0, 0,  0,  "beq_z0"};
    tbl[9]  = '{6'h05, 6'h00, 1'b1, 0,   4,  4'd1, 1'b0, 1'b0, 1'b0, 0,  0,  "bne_z1"};
    tbl[10] = '{6'h05, 6'h00, 1'b0, 0,   4,  4'd1, 1'b1, 1'b0, 1'b0, 0,  0,  "bne_z0"};
    tbl[11] = '{6'h23, 6'h00, 1'b0, 3,   8,  4'd0, 1'b0, 1'b1, 1'b0, 4,  0,  "lw_w3"};
    tbl[12] = '{6'h2b, 6'h00, 1'b0, 0,   5,  4'd0, 1'b0, 1'b0, 1'b0, 1,  1,  "sw_w0"};
    tbl[13] = '{6'h2b, 6'h00, 1'b0, 255, 19, 4'd0, 1'b0, 1'b0, 1'b1, 15, 15, "sw_noack"};
    tbl[14] = '{6'h23, 6'h00, 1'b0, 14,  19, 4'd0, 1'b0, 1'b1, 1'b0, 15, 0,  "lw_ack_at_limit"};
    tbl[15] = '{6'h23, 6'h00, 1'b0, 15,  19, 4'd0, 1'b0, 1'b0, 1'b1, 15, 0,  "lw_ack_late"};
    tbl[16] = '{6'h3f, 6'h00, 1'b0, 0,   3,  4'd0, 1'b0, 1'b0, 1'b1, 0,  0,  "op_3f"};
    tbl[17] = '{6'h00, 6'h21, 1'b0, 0,   3,  4'd0, 1'b0, 1'b0, 1'b1, 0,  0,  "r_bad_funct"};
    tbl[18] = '{6'h02, 6'h00, 1'b0, 0,   3,  4'd0, 1'b0, 1'b0, 1'b1, 0,  0,  "op_02"};
    rfn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

    reset    = 1'b0;
    opcode   = 6'h00;
    funct    = 6'h00;
    alu_zero = 1'b0;
    mem_ack  = 1'b0;

    // Reset held three cycles: all outputs low throughout.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_ack = 1'b1;
      check($sformatf("reset_hold%0d", i), 32'(act), 32'h0);
    end
    reset   = 1'b1;
    mem_ack = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 19; i++) begin
      run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].w);
      check({tbl[i].name, " len"},   32'(obs_len),   32'(tbl[i].len));
      check({tbl[i].name, " alu"},   32'(obs_alu),   32'(tbl[i].alu));
      check({tbl[i].name, " pcsel"}, 32'(obs_pcsel), 32'(tbl[i].pcsel));
      check({tbl[i].name, " rfwe"},  32'(obs_rfwe),  32'(tbl[i].rfwe));
      check({tbl[i].name, " ill"},   32'(obs_ill),   32'(tbl[i].ill));
      check({tbl[i].name, " req"},   32'(obs_req),   32'(tbl[i].req));
      check({tbl[i].name, " we"},    32'(obs_we),    32'(tbl[i].we));
    end

    // Reset asserted mid-MEM: MEM_req must drop without waiting for a clock edge.
    opcode  = 6'h23;
    funct   = 6'h00;
    mem_ack = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midmem_req_before", 32'(MEM_req), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("midmem_req_async", 32'(MEM_req), 32'h0);
    check("midmem_outs_async", 32'(act), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run_instr(6'h00, 6'h20, 1'b0, 0);
    check("after_reset_add_len", 32'(obs_len), 32'd4);
    run_instr(6'h23, 6'h00, 1'b0, 0);
    check("after_reset_lw_rfwe", 32'(obs_rfwe), 32'h1);

    // Random instruction stream against the trace model.
    for (int n = 0; n < 200; n++) begin
      fn = 6'($urandom);
      case ($urandom_range(0, 7))
        0: begin op = 6'h00; fn = rfn[$urandom_range(0, 4)]; end
        1: op = 6'h08;
        2: op = 6'h0d;
        3: op = 6'h23;
        4: op = 6'h2b;
        5: op = 6'h04;
        6: op = 6'h05;
        default: op = 6'($urandom);
      endcase
      if ($urandom_range(0, 3) == 0) w = $urandom_range(T - 2, T + 2);
      else                           w = $urandom_range(0, 4);
      run_instr(op, fn, 1'($urandom), w);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
